mod_ramp_gen: RTL and testbench
===============================

# mod_ramp_gen

Combined modulation and feedback phase-ramp generator for the closed-loop gyro DAC path. It supersedes the separate modulation and ramp blocks with one parametrised unit. It produces a two-state or four-state bias modulation and a 2π-wrapped step accumulator, sums them into the DAC word, and emits the period trigger consumed by the error demodulator and the feedback step generator.

## Interface
- OUTPUT_BIT, 16, DAC word width; also the modulation amplitude width.
- ACC_BIT, 32, ramp accumulator width; i_step and i_v2pi use this width.
- CNT_BIT, 32, dwell counter width.
- i_clk  in  1  system clock (the DAC clock).
- i_rst  in  1  reset: one clock; reset is synchronous and active-high.
- i_freq_cnt  in  CNT_BIT  dwell per modulation state in clocks; values below 2 are treated as 2.
- i_mode  in  1  0 = two-state (amp0, amp1); 1 = four-state (amp0, amp1, amp2, amp3).
- i_amp0..i_amp3  in  OUTPUT_BIT each  signed modulation level for each state.
- i_step  in  ACC_BIT  signed ramp increment, applied once per period.
- i_v2pi  in  ACC_BIT  2π span in accumulator LSBs; unsigned, must be >0.
- i_fb_on  in  1  enables ramp accumulation; when low, the accumulator is held at 0.
- o_mod  out  OUTPUT_BIT  current modulation level.
- o_status  out  2  index of the current modulation state.
- o_step_trig  out  1  one-cycle pulse on the last clock of each full modulation period.
- o_ramp  out  OUTPUT_BIT  accumulator top bits, acc[ACC_BIT-1 -: OUTPUT_BIT].
- o_dac  out  OUTPUT_BIT  registered o_ramp + o_mod, modulo 2^OUTPUT_BIT.

## Operation
- Shadow registers hold freq_cnt, mode and amp0..3.
  - They load on the first clock after reset and on every o_step_trig clock.
  - Mid-period input changes never alter the running period.
- State FSM:
  - Mode 0 sequence: S0→S1→S0.
  - Mode 1 sequence: S0→S1→S2→S3→S0.
  - Each state lasts exactly max(freq_cnt,2) clocks.
  - A down-counter loads dwell−1 on state entry and advances the state when it reaches 0.
- A mode change takes effect only at the period boundary. If the shadowed mode is 0, a stale state index above 1 goes to S0.
- o_mod equals the shadowed amp of the current state. o_status equals the state index.
- o_step_trig is high on the final clock of S1 (mode 0) or S3 (mode 1).
- Accumulator update on the clock after o_step_trig, computed at ACC_BIT+2 signed width:
  - sum = acc + step.
  - If sum ≥ v2pi: acc ← sum − v2pi.
  - If sum < 0: acc ← sum + v2pi.
  - Otherwise acc ← sum.
- |step| ≥ v2pi is out of contract. The only requirement in that case is a single correction per update; the result is never re-wrapped.
- i_fb_on low clears acc to 0 on the next clock and overrides any pending update.
- o_dac wraps silently; it does not saturate.

## Timing
- Reset values: o_mod=0, o_status=0, o_step_trig=0, o_ramp=0, o_dac=0, acc=0, counter=0.
- First state S0 begins on the clock after i_rst falls, using the shadows sampled on that clock.
- o_mod and o_status are registered and change on the clock of the state transition.
- o_ramp follows o_step_trig by 1 clock.
- o_dac lags o_mod and o_ramp by 1 clock.
- Period length: 2·dwell clocks in mode 0, 4·dwell clocks in mode 1.
- i_rst asserted mid-period aborts the period. No o_step_trig is issued, and all state returns to reset values on that clock.
- i_fb_on falling on the same clock as o_step_trig: the clear wins and acc=0.

## Structure
- A shared gyro package holds the state encoding (S0..S3) and the MIN_DWELL=2 constant.
- One sub-module, ramp_wrap_acc: the accumulator with v2pi wrap and the fb_on clear.
- The FSM, counter, shadows and output register live in the top.

## Test plan
- Mode 0 timing: freq_cnt=5, amp0=100, amp1=−100.
  - o_mod alternates every 5 clocks.
  - o_step_trig pulses every 10 clocks, on the last clock of S1.
- Mode 1 timing: freq_cnt=3, amps 10/20/−10/−20.
  - Sequence repeats every 12 clocks.
  - o_status goes 0,1,2,3.
- Positive wrap: v2pi=1000, step=300, fb_on=1.
  - acc runs 300, 600, 900, 200.
  - o_ramp follows acc's top bits one clock after each trig.
- Negative wrap: v2pi=1000, step=−300, from acc=0.
  - acc runs 700, 400, 100, 800.
- Shadowing: change freq_cnt from 4 to 8 mid-period.
  - The current period stays at 4-clock dwells; the next period uses 8.
  - freq_cnt=0 gives 2-clock dwells.
- Reset and clear:
  - i_rst mid-S1: all outputs 0 the next clock, no trig.
  - fb_on dropped on a trig clock: acc=0.

Source files
------------

// File: rtl/mod_ramp_gen_pkg.sv
// Shared definitions for the gyro modulation / phase-ramp generator.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package mod_ramp_gen_pkg;

   // Modulation state index; the encoding is also what o_status reports.
   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2,
      S3 = 2'd3
   } state_e;

   // Shortest dwell per modulation state, in clocks.
   localparam int MIN_DWELL = 2;

   // Successor state within a period. In two-state mode, any index other
   // than S0 returns to S0, so a stale S2/S3 index cannot persist.
   function automatic state_e next_state(input state_e cur, input logic mode);
      logic [1:0] nxt;
      if (!mode) begin
         nxt = (cur == S0) ? 2'd1 : 2'd0;
      end else begin
         nxt = cur + 2'd1;
      end
      return state_e'(nxt);
   endfunction

   // Final state of a full modulation period for the given mode.
   function automatic state_e last_state(input logic mode);
      return mode ? S3 : S1;
   endfunction

endpackage

// File: rtl/mod_ramp_gen_if.sv
// Bus bundle for mod_ramp_gen: configuration inputs and DAC-side outputs.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are level/strobe, free running.
// master drives i_* and observes o_*; slave (the generator) does the reverse.
interface mod_ramp_gen_if #(
   parameter int OUTPUT_BIT = 16,
   parameter int ACC_BIT    = 32,
   parameter int CNT_BIT    = 32
);
   logic [CNT_BIT-1:0]    i_freq_cnt;
   logic                  i_mode;
   logic [OUTPUT_BIT-1:0] i_amp0;
   logic [OUTPUT_BIT-1:0] i_amp1;
   logic [OUTPUT_BIT-1:0] i_amp2;
   logic [OUTPUT_BIT-1:0] i_amp3;
   logic [ACC_BIT-1:0]    i_step;
   logic [ACC_BIT-1:0]    i_v2pi;
   logic                  i_fb_on;
   logic [OUTPUT_BIT-1:0] o_mod;
   logic [1:0]            o_status;
   logic                  o_step_trig;
   logic [OUTPUT_BIT-1:0] o_ramp;
   logic [OUTPUT_BIT-1:0] o_dac;

   modport master (
      output i_freq_cnt, i_mode, i_amp0, i_amp1, i_amp2, i_amp3,
      output i_step, i_v2pi, i_fb_on,
      input  o_mod, o_status, o_step_trig, o_ramp, o_dac
   );

   modport slave (
      input  i_freq_cnt, i_mode, i_amp0, i_amp1, i_amp2, i_amp3,
      input  i_step, i_v2pi, i_fb_on,
      output o_mod, o_status, o_step_trig, o_ramp, o_dac
   );
endinterface

// File: rtl/ramp_wrap_acc.sv
// Phase-ramp accumulator wrapped into [0, v2pi), with a hard clear from fb_on.
// Latency: acc updates on the clock after i_upd; i_fb_on low clears on the next clock.
// Backpressure: none.
// Ports: i_clk, i_rst (sync, active high), i_fb_on, i_upd (period strobe),
//        i_step (signed increment), i_v2pi (unsigned span), o_ramp (acc top bits).
module ramp_wrap_acc #(
   parameter int ACC_BIT    = 32,
   parameter int OUTPUT_BIT = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_fb_on,
   input  logic                  i_upd,
   input  logic [ACC_BIT-1:0]    i_step,
   input  logic [ACC_BIT-1:0]    i_v2pi,
   output logic [OUTPUT_BIT-1:0] o_ramp
);
   localparam int W = ACC_BIT + 2;

   logic [ACC_BIT-1:0]  acc_q, acc_d;
   logic signed [W-1:0] sum;
   logic signed [W-1:0] v2pi_x;

   // acc is an unsigned phase in [0, v2pi); two guard bits keep acc+step and
   // the compare against v2pi exact for any step sign.
   always_comb begin
      sum    = signed'({2'b00, acc_q}) + signed'({{2{i_step[ACC_BIT-1]}}, i_step});
      v2pi_x = signed'({2'b00, i_v2pi});
      acc_d  = acc_q;
      if (!i_fb_on) begin
         acc_d = '0;
      end else if (i_upd) begin
         // One correction only; an oversized step is not re-wrapped.
         if (sum >= v2pi_x) begin
            acc_d = ACC_BIT'(sum - v2pi_x);
         end else if (sum[W-1]) begin
            acc_d = ACC_BIT'(sum + v2pi_x);
         end else begin
            acc_d = ACC_BIT'(sum);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign o_ramp = acc_q[ACC_BIT-1 -: OUTPUT_BIT];

endmodule

// File: rtl/mod_ramp_gen.sv
// Two/four-state bias modulation plus wrapped phase ramp, summed into the DAC word.
// Latency: o_mod/o_status registered on the state change; o_ramp 1 clk after trig; o_dac 1 clk after both.
// Backpressure: none; free running on every clock.
// Ports: i_clk, i_rst (sync, active high), bus (slave): config in, o_mod/o_status/o_step_trig/o_ramp/o_dac out.
module mod_ramp_gen
   import mod_ramp_gen_pkg::*;
#(
   parameter int OUTPUT_BIT = 16,
   parameter int ACC_BIT    = 32,
   parameter int CNT_BIT    = 32
) (
   input  logic           i_clk,
   input  logic           i_rst,
   mod_ramp_gen_if.slave  bus
);
   logic                             started_q;
   state_e                           state_q, state_d;
   logic [CNT_BIT-1:0]               cnt_q, cnt_d;
   logic [CNT_BIT-1:0]               freq_sh_q, freq_sh_d;
   logic                             mode_sh_q, mode_sh_d;
   logic [3:0][OUTPUT_BIT-1:0]       amp_sh_q, amp_sh_d;
   logic [OUTPUT_BIT-1:0]            mod_q, mod_d;
   logic [1:0]                       status_q, status_d;
   logic                             trig_q, trig_d;
   logic [OUTPUT_BIT-1:0]            dac_q, dac_d;
   logic [CNT_BIT-1:0]               dwell_m1;
   logic                             load;
   logic [OUTPUT_BIT-1:0]            ramp;

   // Shadows refresh when the first period starts and at every period
   // boundary, so a running period never sees mid-period input changes.
   assign load = !started_q || trig_q;

   // Next-state: shadows, dwell counter and state index.
   always_comb begin
      freq_sh_d = freq_sh_q;
      mode_sh_d = mode_sh_q;
      amp_sh_d  = amp_sh_q;
      if (load) begin
         freq_sh_d = bus.i_freq_cnt;
         mode_sh_d = bus.i_mode;
         amp_sh_d  = {bus.i_amp3, bus.i_amp2, bus.i_amp1, bus.i_amp0};
      end

      if (freq_sh_d < CNT_BIT'(MIN_DWELL)) begin
         dwell_m1 = CNT_BIT'(MIN_DWELL - 1);
      end else begin
         dwell_m1 = freq_sh_d - CNT_BIT'(1);
      end

      state_d = state_q;
      cnt_d   = cnt_q;
      if (load) begin
         // Period boundary (or first period): always restart at S0 with the
         // freshly shadowed dwell, whatever the new mode is.
         state_d = S0;
         cnt_d   = dwell_m1;
      end else if (cnt_q == '0) begin
         state_d = next_state(state_q, mode_sh_q);
         cnt_d   = dwell_m1;
      end else begin
         cnt_d   = cnt_q - CNT_BIT'(1);
      end
   end

   // Outputs: registered copies of what the next state implies.
   always_comb begin
      mod_d    = amp_sh_d[state_d];
      status_d = state_d;
      trig_d   = (state_d == last_state(mode_sh_d)) && (cnt_d == '0);
      dac_d    = ramp + mod_q;
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         started_q <= 1'b0;
         state_q   <= S0;
         cnt_q     <= '0;
         freq_sh_q <= '0;
         mode_sh_q <= 1'b0;
         amp_sh_q  <= '0;
         mod_q     <= '0;
         status_q  <= '0;
         trig_q    <= 1'b0;
         dac_q     <= '0;
      end else begin
         started_q <= 1'b1;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         freq_sh_q <= freq_sh_d;
         mode_sh_q <= mode_sh_d;
         amp_sh_q  <= amp_sh_d;
         mod_q     <= mod_d;
         status_q  <= status_d;
         trig_q    <= trig_d;
         dac_q     <= dac_d;
      end
   end

   ramp_wrap_acc #(
      .ACC_BIT    (ACC_BIT),
      .OUTPUT_BIT (OUTPUT_BIT)
   ) u_acc (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_fb_on (bus.i_fb_on),
      .i_upd   (trig_q),
      .i_step  (bus.i_step),
      .i_v2pi  (bus.i_v2pi),
      .o_ramp  (ramp)
   );

   assign bus.o_mod       = mod_q;
   assign bus.o_status    = status_q;
   assign bus.o_step_trig = trig_q;
   assign bus.o_ramp      = ramp;
   assign bus.o_dac       = dac_q;

endmodule

// File: tb/tb_mod_ramp_gen.sv
// Directed bench for mod_ramp_gen: table of period/ramp vectors plus hand
// sequences for shadowing, mid-period reset and fb_on clear on a trig clock.
module tb_mod_ramp_gen;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mod_ramp_gen_if bus();

   mod_ramp_gen dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic             mode;
      logic [31:0]      freq;
      logic [3:0][15:0] amp;       // {amp3, amp2, amp1, amp0}
      logic [31:0]      step;
      logic [31:0]      v2pi;
      int               dwell;     // expected clocks per state
      logic [3:0][15:0] ramp_exp;  // o_ramp after trig 4,3,2,1
   } vec_t;

   vec_t vecs [4];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] outs();
      return {13'd0, bus.o_status, bus.o_step_trig, bus.o_mod, bus.o_ramp, bus.o_dac};
   endfunction

   function automatic logic [63:0] pack(input logic [1:0] st, input logic tr,
                                        input logic [15:0] md, input logic [15:0] rp,
                                        input logic [15:0] dc);
      return {13'd0, st, tr, md, rp, dc};
   endfunction

   task automatic set_cfg(input logic mode, input logic [31:0] freq,
                          input logic [3:0][15:0] amp, input logic [31:0] step,
                          input logic [31:0] v2pi);
      bus.i_mode     = mode;
      bus.i_freq_cnt = freq;
      bus.i_amp0     = amp[0];
      bus.i_amp1     = amp[1];
      bus.i_amp2     = amp[2];
      bus.i_amp3     = amp[3];
      bus.i_step     = step;
      bus.i_v2pi     = v2pi;
      bus.i_fb_on    = 1'b1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int nst, per, ntrig;
      logic [1:0]  st_e;
      logic        tr_e;
      logic [15:0] mod_e, ramp_e, dac_e, prev_ramp, prev_mod;
      set_cfg(v.mode, v.freq, v.amp, v.step, v.v2pi);
      rst = 1'b1;
      tick();
      tick();
      chk($sformatf("vec%0d reset", idx), outs(), 64'd0);
      rst = 1'b0;
      nst = v.mode ? 4 : 2;
      per = nst * v.dwell;
      ntrig = 0;
      prev_ramp = '0;
      prev_mod  = '0;
      for (int k = 0; k <= 4 * per; k++) begin
         tick();
         st_e   = 2'((k / v.dwell) % nst);
         tr_e   = ((k % per) == per - 1);
         mod_e  = v.amp[st_e];
         ramp_e = (ntrig == 0) ? 16'd0 : v.ramp_exp[ntrig-1];
         dac_e  = prev_ramp + prev_mod;
         chk($sformatf("vec%0d k%0d", idx, k), outs(), pack(st_e, tr_e, mod_e, ramp_e, dac_e));
         prev_ramp = ramp_e;
         prev_mod  = mod_e;
         if (tr_e) ntrig++;
      end
   endtask

   initial begin
      int tq[$];
      int t0, t1;
      rst = 1'b1;
      set_cfg(1'b0, 32'd5, 64'd0, 32'd0, 32'd1000);

      // mode 0, dwell 5, +300 of 1000 (scaled to the top 16 bits)
      vecs[0] = '{1'b0, 32'd5, {16'd0, 16'd0, 16'hFF9C, 16'd100},
                  32'd300 << 16, 32'd1000 << 16, 5, {16'd200, 16'd900, 16'd600, 16'd300}};
      // mode 1, dwell 3, -300 of 1000
      vecs[1] = '{1'b1, 32'd3, {16'hFFEC, 16'hFFF6, 16'd20, 16'd10},
                  32'hFED4_0000, 32'd1000 << 16, 3, {16'd800, 16'd100, 16'd400, 16'd700}};
      // freq 0 clamps to dwell 2; ramp 1,2->wrap 0,1 of 3
      vecs[2] = '{1'b0, 32'd0, {16'd0, 16'd0, 16'hFFF9, 16'd7},
                  32'd1 << 16, 32'd3 << 16, 2, {16'd1, 16'd0, 16'd2, 16'd1}};
      // freq 1 clamps to dwell 2; DAC sum wraps past 0x7FFF/0xFFFF
      vecs[3] = '{1'b1, 32'd1, {16'd3, 16'h8000, 16'hFFFE, 16'h7FFF},
                  32'd4 << 16, 32'd5 << 16, 2, {16'd1, 16'd2, 16'd3, 16'd4}};

      for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

      // Shadowing: freq 4 -> 8 and amp0 11 -> 55 mid-period.
      set_cfg(1'b0, 32'd4, {16'd0, 16'd0, 16'd22, 16'd11}, 32'd0, 32'd1000);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (bus.o_step_trig) tq.push_back(k);
         if (k == 1) begin
            bus.i_freq_cnt = 32'd8;
            bus.i_amp0     = 16'd55;
         end
         if (k == 2)  chk("shadow amp held", {48'd0, bus.o_mod}, 64'd11);
         if (k == 8)  chk("shadow amp new", {46'd0, bus.o_status, bus.o_mod}, {46'd0, 2'd0, 16'd55});
         if (k == 12) chk("shadow dwell8 s0", {62'd0, bus.o_status}, 64'd0);
         if (k == 16) chk("shadow dwell8 s1", {62'd0, bus.o_status}, 64'd1);
      end
      t0 = (tq.size() > 0) ? tq[0] : -1;
      t1 = (tq.size() > 1) ? tq[1] : -1;
      chk("shadow trig count", 64'(tq.size()), 64'd2);
      chk("shadow trig0", 64'(t0), 64'd7);
      chk("shadow trig1", 64'(t1), 64'd23);

      // Reset mid-S1 of the second period, ramp already non-zero.
      set_cfg(1'b0, 32'd5, {16'd0, 16'd0, 16'd50, 16'd40}, 32'd300 << 16, 32'd1000 << 16);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k <= 16; k++) tick();
      chk("pre-rst state", {46'd0, bus.o_status, bus.o_ramp}, {46'd0, 2'd1, 16'd300});
      rst = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk($sformatf("mid rst t%0d", k), outs(), 64'd0);
      end
      rst = 1'b0;

      // fb_on dropped on a trig clock: clear beats the update.
      set_cfg(1'b0, 32'd2, {16'd0, 16'd0, 16'd2, 16'd1}, 32'd300 << 16, 32'd1000 << 16);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int k = 0; k <= 12; k++) begin
         tick();
         if (k == 4)  chk("fb ramp first", {48'd0, bus.o_ramp}, 64'd300);
         if (k == 7) begin
            chk("fb trig clock", {63'd0, bus.o_step_trig}, 64'd1);
            bus.i_fb_on = 1'b0;
         end
         if (k == 8) begin
            chk("fb clear wins", {48'd0, bus.o_ramp}, 64'd0);
            bus.i_fb_on = 1'b1;
         end
         if (k == 12) chk("fb resume", {48'd0, bus.o_ramp}, 64'd300);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
